spi_cfg_ctrl: RTL
=================

Name: spi_cfg_ctrl

Overview:
- SPI peripheral-side configuration controller: receives SPI mode-0 write transactions and commits them into the five configuration registers that drive the output-enable and PWM datapath.
- Sits between the dedicated input pins (ui_in) and the PWM/output-enable logic inside the top-level user project.
- All SPI pins are asynchronous to clk; the block synchronizes them, deframes 16-bit transactions and commits only valid, complete writes.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer; minimum 2.
- MAX_ADDR, 4, highest writable register address; any address above it is ignored.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sclk  input  1  SPI clock from the controller; asynchronous
- copi  input  1  SPI data, controller to peripheral; asynchronous
- ncs  input  1  SPI chip select, active low; asynchronous
- en_reg_out_7_0  output  8  register at address 0x00
- en_reg_out_15_8  output  8  register at address 0x01
- en_reg_pwm_7_0  output  8  register at address 0x02
- en_reg_pwm_15_8  output  8  register at address 0x03
- pwm_duty_cycle  output  8  register at address 0x04
- frame_err  output  1  one-clk pulse when a frame is discarded for bad length

Behaviour:
- Reset: all five registers are 0x00. frame_err, bit counter, shift register and synchronizers are 0. ncs synchronizer chain resets to 1.
- Synchronizers:
  - sclk, copi and ncs each pass through SYNC_STAGES flops.
  - One extra history flop on sclk and one on ncs provides edge detection.
- Frame format, MSB first:
  - bit 15 is R/W (1 = write).
  - bits 14:8 are the address.
  - bits 7:0 are the data.
- States: IDLE, SHIFT, COMMIT.
  - IDLE -> SHIFT on the synchronized ncs falling edge. Clear the bit counter and shift register.
  - SHIFT: on each synchronized sclk rising edge while synced ncs = 0, shift copi into the LSB and increment the counter. The 5-bit counter saturates at 17, meaning more than 16 bits were received.
  - SHIFT -> COMMIT on the synchronized ncs rising edge.
  - COMMIT lasts 1 clk, then returns to IDLE.
  - A write commits only if: counter == 16, R/W = 1, and address <= MAX_ADDR.
  - A write commits on the COMMIT cycle. Register outputs change at the 2nd clk edge after the edge that first samples ncs high at the synchronizer output.
- Discard rules:
  - counter != 16: no write; frame_err pulses for 1 clk during COMMIT.
  - R/W = 0 or address > MAX_ADDR: silently ignored; no frame_err.
- Timing constraints:
  - sclk high and low phases each >= 3 clk periods.
  - ncs high time between frames >= 3 clk periods.
  - Violations are undefined behaviour, except that no register changes outside COMMIT.
- sclk edges while ncs is high are ignored.
- An ncs rising edge in IDLE is ignored.
- Reset asserted mid-frame aborts the frame immediately. All registers return to 0x00. After reset release, the controller waits for a fresh ncs falling edge.
- Only one register is written per frame. Unwritten registers hold their value.

Optional Feature:
- Macro SPI_CFG_READBACK_EN.
- When defined:
  - Adds output port cipo (1 bit).
  - For a frame with R/W = 0 and address <= MAX_ADDR, after the 8th sclk rising edge, the addressed register value is loaded. Its bits 7..0 are driven on cipo, changing on each subsequent synchronized sclk falling edge.
  - cipo = 0 whenever ncs is high, the address is invalid, or the frame is a write.
  - Read frames never modify registers.
- When undefined: no cipo port; reads are ignored exactly as in the base behaviour.

Test Plan:
- Reset, then write frame 0x80_F0 (addr 0x00, data 0xF0) -> en_reg_out_7_0 = 0xF0; all others remain 0x00; frame_err never pulses.
- Writes to 0x01..0x04 with data 0xA5, 0x3C, 0x81, 0x7F -> each register matches its data; 0x00 retains the prior value.
- Write to addr 0x05, and read frame 0x04_55 -> no register changes; frame_err stays 0.
- 15-bit frame, then 17-bit frame, each targeting addr 0x04 with data 0x11 -> pwm_duty_cycle unchanged; frame_err pulses exactly once per frame.
- Assert rst_n low after 8 bits of a write to 0x02 holding 0xFF, then release and send a full write of 0x42 to 0x02 -> register is 0x00 after reset, then 0x42; no partial commit.
- With SPI_CFG_READBACK_EN: write 0xC3 to 0x03, then read 0x03 -> cipo shifts out 1,1,0,0,0,0,1,1 on bits 8..15; registers unchanged.

Source files
------------

// File: rtl/spi_cfg_ctrl.sv
// spi_cfg_ctrl: SPI mode-0 peripheral that deframes 16-bit write frames
// (R/W, 7-bit address, 8-bit data, MSB first) into five config registers.
// Optional feature macro: SPI_CFG_READBACK_EN adds a cipo read-back path.
module spi_cfg_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_err
`ifdef SPI_CFG_READBACK_EN
  ,
  output logic       cipo
`endif
);

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned FRM_W  = 16;
  localparam int unsigned ADDR_W = 7;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(16);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(17);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(MAX_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [SYNC_STAGES-1:0]   r_sclk_sync;
  logic [SYNC_STAGES-1:0]   r_copi_sync;
  logic [SYNC_STAGES-1:0]   r_ncs_sync;
  logic                     r_sclk_d;
  logic                     r_ncs_d;
  logic [CNT_W-1:0]         r_cnt;
  logic [FRM_W-1:0]         r_sr;
  logic [7:0]               r_reg0;
  logic [7:0]               r_reg1;
  logic [7:0]               r_reg2;
  logic [7:0]               r_reg3;
  logic [7:0]               r_reg4;
  logic                     r_frame_err;

  logic                     w_sclk_s;
  logic                     w_copi_s;
  logic                     w_ncs_s;
  logic                     w_sclk_rise;
  logic                     w_ncs_fall;
  logic                     w_ncs_rise;
  logic [FRM_W-1:0]         w_sr_nxt;
  logic                     w_rw;
  logic [ADDR_W-1:0]        w_addr;
  logic [7:0]               w_data;
  logic                     w_addr_ok;
  logic                     w_clr;
  logic                     w_shift_en;
  logic                     w_commit;
  logic                     w_frame_err_nxt;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
  assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_ncs_fall  = ~w_ncs_s & r_ncs_d;
  assign w_ncs_rise  = w_ncs_s & ~r_ncs_d;
  assign w_sr_nxt    = {r_sr[FRM_W-2:0], w_copi_s};
  assign w_rw        = r_sr[15];
  assign w_addr      = r_sr[14:8];
  assign w_data      = r_sr[7:0];
  assign w_addr_ok   = (w_addr <= ADDR_MAX);

  // Input synchronizers plus one history flop on sclk and ncs for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
      r_ncs_sync  <= '1;
      r_sclk_d    <= 1'b0;
      r_ncs_d     <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
      r_sclk_d    <= w_sclk_s;
      r_ncs_d     <= w_ncs_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and control strobes
  always_comb begin
    w_state_nxt     = r_state;
    w_clr           = 1'b0;
    w_shift_en      = 1'b0;
    w_commit        = 1'b0;
    w_frame_err_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ncs_fall) begin
          w_state_nxt = ST_SHIFT;
          w_clr       = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_ncs_rise) begin
          w_state_nxt     = ST_COMMIT;
          w_frame_err_nxt = (r_cnt != CNT_FULL);
        end else if (w_sclk_rise && !w_ncs_s) begin
          w_shift_en = 1'b1;
        end
      end
      ST_COMMIT: begin
        w_state_nxt = ST_IDLE;
        w_commit    = (r_cnt == CNT_FULL) && w_rw && w_addr_ok;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Frame shift register and saturating bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (w_clr) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (w_shift_en) begin
      r_sr  <= w_sr_nxt;
      r_cnt <= (r_cnt == CNT_SAT) ? CNT_SAT : r_cnt + CNT_W'(1);
    end
  end

  // Length-error pulse, registered so it is high exactly during COMMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // Configuration registers; only a validated frame writes one of them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg0 <= '0;
      r_reg1 <= '0;
      r_reg2 <= '0;
      r_reg3 <= '0;
      r_reg4 <= '0;
    end else if (w_commit) begin
      case (w_addr)
        7'd0:    r_reg0 <= w_data;
        7'd1:    r_reg1 <= w_data;
        7'd2:    r_reg2 <= w_data;
        7'd3:    r_reg3 <= w_data;
        7'd4:    r_reg4 <= w_data;
        default: ;
      endcase
    end
  end

  assign en_reg_out_7_0  = r_reg0;
  assign en_reg_out_15_8 = r_reg1;
  assign en_reg_pwm_7_0  = r_reg2;
  assign en_reg_pwm_15_8 = r_reg3;
  assign pwm_duty_cycle  = r_reg4;
  assign frame_err       = r_frame_err;

`ifdef SPI_CFG_READBACK_EN
  logic       w_sclk_fall;
  logic       w_rd_load;
  logic [7:0] w_rd_val;
  logic [7:0] r_rd_sr;
  logic       r_rd_active;
  logic       r_cipo;

  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  // Header is complete on the 8th rising edge: bit 7 is R/W, bits 6:0 address
  assign w_rd_load   = w_shift_en && (r_cnt == CNT_W'(7)) && !w_sr_nxt[7] &&
                       (w_sr_nxt[6:0] <= ADDR_MAX);

  // Read-back source select from the just-received address
  always_comb begin
    w_rd_val = 8'h00;
    case (w_sr_nxt[6:0])
      7'd0:    w_rd_val = r_reg0;
      7'd1:    w_rd_val = r_reg1;
      7'd2:    w_rd_val = r_reg2;
      7'd3:    w_rd_val = r_reg3;
      7'd4:    w_rd_val = r_reg4;
      default: w_rd_val = 8'h00;
    endcase
  end

  // Read-back shifter: MSB first, advancing on each sclk falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_sr     <= '0;
      r_rd_active <= 1'b0;
      r_cipo      <= 1'b0;
    end else if ((r_state != ST_SHIFT) || w_ncs_s) begin
      r_rd_sr     <= '0;
      r_rd_active <= 1'b0;
      r_cipo      <= 1'b0;
    end else if (w_rd_load) begin
      r_rd_sr     <= w_rd_val;
      r_rd_active <= 1'b1;
    end else if (w_sclk_fall && r_rd_active) begin
      r_cipo  <= r_rd_sr[7];
      r_rd_sr <= {r_rd_sr[6:0], 1'b0};
    end
  end

  assign cipo = r_cipo;
`endif

endmodule
